// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the pipeline sequencer and its counters.
package pipe_pkg;

   typedef enum logic [1:0] {
      HALT  = 2'd0,
      RUN   = 2'd1,
      STEP  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int NREGS_DEF       = 4;
   localparam int STALL_AT_DEF    = 1;
   localparam int FLUSH_DEPTH_DEF = 1;
   localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Advance, retire and stall event counters; one-cycle update latency, never stalls.
module pipe_perf_cnt
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             retire,
   input  logic             stall,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (adv)    cycle_cnt  <= cycle_cnt + 1'b1;
         if (retire) retire_cnt <= retire_cnt + 1'b1;
         if (stall)  stall_cnt  <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctl.sv
// Pipeline sequencer: run/pause/step/drain FSM with stall/flush enables; enables are combinational, valid is registered.
// Performance counters are built only when PIPE_CTL_PERF_EN is defined; otherwise the count ports read 0.
module pipe_ctl
   import pipe_pkg::*;
#(
   parameter int NREGS       = NREGS_DEF,
   parameter int STALL_AT    = STALL_AT_DEF,
   parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic             step,
   input  logic             drain,
   input  logic             stall_req,
   input  logic             flush_req,
   output logic             pc_en,
   output logic [NREGS-1:0] reg_en,
   output logic [NREGS-1:0] reg_bubble,
   output logic [NREGS-1:0] valid,
   output logic             retire,
   output logic             idle,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           state, state_nxt;
   logic             adv, fetch;
   logic [NREGS-1:0] valid_nxt;

   always_comb begin
      adv   = (state == RUN) | (state == STEP) | ((state == DRAIN) & ~pause);
      fetch = adv & (state != DRAIN);
   end

   always_comb begin
      pc_en      = 1'b0;
      reg_en     = '0;
      reg_bubble = '0;
      valid_nxt  = valid;
      if (adv) begin
         reg_en        = '1;
         pc_en         = fetch;
         valid_nxt     = {valid[NREGS-2:0], fetch};
         reg_bubble[0] = ~fetch;
         if (stall_req) begin
            // Upstream of the bubble point holds; a bubble is injected at STALL_AT.
            pc_en      = 1'b0;
            reg_bubble = '0;
            for (int j = 0; j < NREGS; j++) begin
               if (j < STALL_AT) begin
                  reg_en[j]    = 1'b0;
                  valid_nxt[j] = valid[j];
               end
            end
            reg_bubble[STALL_AT] = 1'b1;
            valid_nxt[STALL_AT]  = 1'b0;
         end else if (flush_req) begin
            for (int j = 0; j < NREGS; j++) begin
               if (j < FLUSH_DEPTH) begin
                  reg_bubble[j] = 1'b1;
                  valid_nxt[j]  = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HALT: begin
            if (drain)       state_nxt = HALT;
            else if (!pause) state_nxt = RUN;
            else if (step)   state_nxt = STEP;
         end
         RUN: begin
            if (drain)      state_nxt = DRAIN;
            else if (pause) state_nxt = HALT;
         end
         STEP:    state_nxt = HALT;
         DRAIN:   if (valid_nxt == '0) state_nxt = HALT;
         default: state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HALT;
         valid <= '0;
      end else begin
         state <= state_nxt;
         valid <= valid_nxt;
      end
   end

   assign retire = adv & valid[NREGS-1];
   assign idle   = ~|valid;
   assign halted = (state == HALT);

`ifdef PIPE_CTL_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .retire     (retire),
      .stall      (adv & stall_req),
      .cycle_cnt  (cycle_cnt),
      .retire_cnt (retire_cnt),
      .stall_cnt  (stall_cnt)
   );
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule
